// File: rtl/mips32_boot_pkg.sv
// rtl/mips32_boot_pkg.sv - shared state encoding and frame constants for the boot loader
package mips32_boot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } boot_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam int HDR_BYTES  = 3;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 1;

endpackage

// File: rtl/mips32_word_assembler.sv
// rtl/mips32_word_assembler.sv - packs payload bytes MSB-first into words and keeps the XOR checksum
module mips32_word_assembler
    import mips32_boot_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word,
    output logic [7:0]  o_csum
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;
    logic [7:0]  r_csum;

    // Only three bytes need holding: the fourth is taken straight from the input.
    assign o_word      = {r_shift, i_byte};
    assign o_word_done = i_valid && (r_idx == 2'(WORD_BYTES - 1));
    assign o_csum      = r_csum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
            r_csum  <= 8'd0;
        end else if (i_clear) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
            r_csum  <= 8'd0;
        end else if (i_valid) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
            r_csum  <= r_csum ^ i_byte;
        end
    end

endmodule

// File: rtl/mips32_boot_loader.sv
// rtl/mips32_boot_loader.sv - framed byte-stream loader that fills instruction memory and releases the core
module mips32_boot_loader
    import mips32_boot_pkg::*;
#(
    parameter int         IM_ADDR_W = 10,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_valid,
    input  logic [7:0]           i_rx_data,
    output logic                 o_rx_ready,
    input  logic                 i_reload,
    output logic                 o_im_we,
    output logic [IM_ADDR_W-1:0] o_im_addr,
    output logic [31:0]          o_im_wdata,
    output logic                 o_core_run,
    output logic                 o_load_error,
    output logic [IM_ADDR_W:0]   o_words_loaded
);

    localparam logic [16:0] CAPACITY = 17'd1 << IM_ADDR_W;

    boot_state_t          r_state;
    logic                 r_rx_ready;
    logic                 r_core_run;
    logic                 r_load_error;
    logic [7:0]           r_cnt_hi;
    logic [IM_ADDR_W:0]   r_count;
    logic [IM_ADDR_W:0]   r_words;
    logic                 r_im_we;
    logic [31:0]          r_im_wdata;

    logic                 w_accept;
    logic [15:0]          w_n;
    logic                 w_asm_clear;
    logic                 w_asm_valid;
    logic                 w_word_done;
    logic [31:0]          w_word;
    logic [7:0]           w_csum;
    logic [IM_ADDR_W:0]   w_words_inc;
    logic                 w_last_word;

    assign o_rx_ready  = r_rx_ready && !i_reload;
    assign w_accept    = o_rx_ready && i_rx_valid;
    assign w_n         = {r_cnt_hi, i_rx_data};
    assign w_asm_clear = i_reload || (w_accept && r_state == CNT_LO);
    assign w_asm_valid = w_accept && (r_state == DATA);
    assign w_words_inc = r_words + {{IM_ADDR_W{1'b0}}, 1'b1};
    // No write can still be pending when a word completes, so r_words is the index of the word in flight.
    assign w_last_word = (w_words_inc == r_count);

    mips32_word_assembler u_asm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_asm_clear),
        .i_valid     (w_asm_valid),
        .i_byte      (i_rx_data),
        .o_word_done (w_word_done),
        .o_word      (w_word),
        .o_csum      (w_csum)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_rx_ready   <= 1'b0;
            r_core_run   <= 1'b0;
            r_load_error <= 1'b0;
            r_cnt_hi     <= 8'd0;
            r_count      <= '0;
            r_words      <= '0;
            r_im_we      <= 1'b0;
            r_im_wdata   <= 32'd0;
        end else begin
            r_im_we <= w_word_done;
            if (w_word_done) begin
                r_im_wdata <= w_word;
            end
            if (r_im_we) begin
                r_words <= w_words_inc;
            end
            if (r_state == IDLE) begin
                r_rx_ready <= 1'b1;
            end

            if (i_reload) begin
                r_state      <= IDLE;
                r_rx_ready   <= 1'b1;
                r_core_run   <= 1'b0;
                r_load_error <= 1'b0;
                r_words      <= '0;
            end else if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        if (i_rx_data == SYNC_BYTE) begin
                            r_state <= CNT_HI;
                        end
                    end
                    CNT_HI: begin
                        r_cnt_hi <= i_rx_data;
                        r_state  <= CNT_LO;
                    end
                    CNT_LO: begin
                        r_count <= w_n[IM_ADDR_W:0];
                        r_words <= '0;
                        if ({1'b0, w_n} > CAPACITY) begin
                            r_state      <= ERR;
                            r_rx_ready   <= 1'b0;
                            r_load_error <= 1'b1;
                        end else if (w_n == 16'd0) begin
                            r_state <= CSUM;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        if (w_word_done && w_last_word) begin
                            r_state <= CSUM;
                        end
                    end
                    CSUM: begin
                        r_rx_ready <= 1'b0;
                        if (i_rx_data == w_csum) begin
                            r_state    <= RUN;
                            r_core_run <= 1'b1;
                        end else begin
                            r_state      <= ERR;
                            r_load_error <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign o_im_we        = r_im_we;
    assign o_im_addr      = r_words[IM_ADDR_W-1:0];
    assign o_im_wdata     = r_im_wdata;
    assign o_core_run     = r_core_run;
    assign o_load_error   = r_load_error;
    assign o_words_loaded = r_words;

endmodule

// File: tb/tb_mips32_boot_loader.sv
// tb/tb_mips32_boot_loader.sv - directed frame loads with a write scoreboard for the boot loader
module tb_mips32_boot_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          reload = 1'b0;
    logic          rx_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          core_run;
    logic          load_error;
    logic [AW:0]   words_loaded;

    int n_vec = 0;
    int n_err = 0;
    int n_we  = 0;
    int we0;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] e;
    logic [31:0]    wbuf[0:1023];

    mips32_boot_loader #(.IM_ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx_valid     (rx_valid),
        .i_rx_data      (rx_data),
        .o_rx_ready     (rx_ready),
        .i_reload       (reload),
        .o_im_we        (im_we),
        .o_im_addr      (im_addr),
        .o_im_wdata     (im_wdata),
        .o_core_run     (core_run),
        .o_load_error   (load_error),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && im_we) begin
            n_we++;
            if (exp_q.size() == 0) begin
                chk("we_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("im_addr", 64'(im_addr), 64'(e[AW+31:32]));
                chk("im_wdata", 64'(im_wdata), 64'(e[31:0]));
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge with rx_valid still high.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 1'b0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 40 && !ok; t++) begin
            ok = rx_ready;
            @(negedge clk);
        end
        chk("rx_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_frame(input int n, input logic [15:0] cnt, input logic [7:0] cs_xor, input bit gaps);
        logic [7:0] cs = 8'd0;
        logic [7:0] b;
        send_byte(8'hA5, gaps);
        send_byte(cnt[15:8], gaps);
        send_byte(cnt[7:0], gaps);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({AW'(i), wbuf[i]});
            for (int k = 0; k < 4; k++) begin
                b  = wbuf[i][31-8*k -: 8];
                cs = cs ^ b;
                send_byte(b, gaps);
            end
        end
        send_byte(cs ^ cs_xor, gaps);
        rx_valid = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #3;
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_im_we", 64'(im_we), 64'd0);
        chk("rst_im_addr", 64'(im_addr), 64'd0);
        chk("rst_im_wdata", 64'(im_wdata), 64'd0);
        chk("rst_core_run", 64'(core_run), 64'd0);
        chk("rst_load_error", 64'(load_error), 64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", 64'(rx_ready), 64'd1);

        wbuf[0] = 32'h20080005;
        wbuf[1] = 32'h0000000C;
        send_frame(2, 16'd2, 8'h00, 1'b0);
        chk("a_core_run", 64'(core_run), 64'd1);
        chk("a_rx_ready", 64'(rx_ready), 64'd0);
        chk("a_words", 64'(words_loaded), 64'd2);
        chk("a_load_error", 64'(load_error), 64'd0);
        chk("a_pending", 64'(exp_q.size()), 64'd0);
        do_reload();
        chk("rl_core_run", 64'(core_run), 64'd0);
        chk("rl_words", 64'(words_loaded), 64'd0);
        chk("rl_rx_ready", 64'(rx_ready), 64'd1);

        send_frame(2, 16'd2, 8'h03, 1'b0);
        chk("bad_load_error", 64'(load_error), 64'd1);
        chk("bad_core_run", 64'(core_run), 64'd0);
        chk("bad_rx_ready", 64'(rx_ready), 64'd0);
        chk("bad_words", 64'(words_loaded), 64'd2);
        chk("bad_pending", 64'(exp_q.size()), 64'd0);
        do_reload();
        chk("bad_rl_load_error", 64'(load_error), 64'd0);
        chk("bad_rl_rx_ready", 64'(rx_ready), 64'd1);

        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        #1;
        chk("reload_blocks_ready", 64'(rx_ready), 64'd0);
        @(negedge clk);
        reload   = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);

        we0 = n_we;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_frame(0, 16'd0, 8'h00, 1'b0);
        chk("empty_writes", 64'(n_we), 64'(we0));
        chk("empty_core_run", 64'(core_run), 64'd1);
        chk("empty_words", 64'(words_loaded), 64'd0);
        do_reload();

        we0 = n_we;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        rx_valid = 1'b0;
        chk("big_load_error", 64'(load_error), 64'd1);
        chk("big_rx_ready", 64'(rx_ready), 64'd0);
        chk("big_core_run", 64'(core_run), 64'd0);
        @(negedge clk);
        chk("big_writes", 64'(n_we), 64'(we0));
        do_reload();

        for (int i = 0; i < 1024; i++) wbuf[i] = $urandom;
        send_frame(1024, 16'h0400, 8'h00, 1'b0);
        chk("max_core_run", 64'(core_run), 64'd1);
        chk("max_words", 64'(words_loaded), 64'd1024);
        chk("max_pending", 64'(exp_q.size()), 64'd0);
        do_reload();

        wbuf[0] = 32'h20080005;
        wbuf[1] = 32'h0000000C;
        wbuf[2] = 32'hDEADBEEF;
        send_frame(3, 16'd3, 8'h00, 1'b1);
        chk("gap_core_run", 64'(core_run), 64'd1);
        chk("gap_words", 64'(words_loaded), 64'd3);
        chk("gap_pending", 64'(exp_q.size()), 64'd0);
        do_reload();

        exp_q.push_back({AW'(0), 32'h20080005});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        rx_valid = 1'b0;
        chk("mid_words", 64'(words_loaded), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("mid_rst_im_we", 64'(im_we), 64'd0);
        chk("mid_rst_im_addr", 64'(im_addr), 64'd0);
        chk("mid_rst_im_wdata", 64'(im_wdata), 64'd0);
        chk("mid_rst_words", 64'(words_loaded), 64'd0);
        chk("mid_pending", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wbuf[0] = 32'h20080005;
        wbuf[1] = 32'h0000000C;
        send_frame(2, 16'd2, 8'h00, 1'b0);
        chk("post_rst_core_run", 64'(core_run), 64'd1);
        chk("post_rst_words", 64'(words_loaded), 64'd2);
        chk("post_rst_pending", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
